// File: rtl/fw_loader.sv
// Firmware image loader: holds the 6502 in reset, streams an image into memory
// from BASE_ADDR upward, writes the reset vector at $FFFC/$FFFD, then releases
// the CPU.
//
// state  | meaning
// IDLE   | waiting for start; CPU held in reset
// LOAD   | accepting stream bytes, one memory write per handshake
// VEC_LO | writing reset vector low byte to $FFFC
// VEC_HI | writing reset vector high byte to $FFFD
// DONE   | image loaded, CPU released; start reloads

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 16'h0600
`endif

module fw_loader #(
   parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
   parameter int                    DATA_WIDTH = `REG_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = `INSTRUCTION_BASE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] len,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  cpu_reset_n,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [2:0] {IDLE, LOAD, VEC_LO, VEC_HI, DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   LIMIT   = (ADDR_WIDTH+1)'(32'hFFFC);
   localparam logic [ADDR_WIDTH-1:0] VEC_LOA = ADDR_WIDTH'(32'hFFFC);
   localparam logic [ADDR_WIDTH-1:0] VEC_HIA = ADDR_WIDTH'(32'hFFFD);
   localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] ptr, ptr_nx;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
   logic [ADDR_WIDTH-1:0] len_q, len_nx;
   logic                  rdy_nx, we_nx, cpu_nx, busy_nx, done_nx, err_nx;
   logic [ADDR_WIDTH-1:0] addr_nx;
   logic [DATA_WIDTH-1:0] din_nx;
   logic                  range_ok;

   // Image must end at or below the reset vector; extra bit prevents wrap.
   assign range_ok = ({1'b0, BASE_ADDR} + {1'b0, len}) <= LIMIT;

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      len_nx   = len_q;
      rdy_nx   = s_ready;
      we_nx    = 1'b0;
      addr_nx  = mem_addr;
      din_nx   = mem_din;
      cpu_nx   = cpu_reset_n;
      busy_nx  = busy;
      done_nx  = done;
      err_nx   = err;
      unique case (state)
         IDLE, DONE: begin
            if (state == DONE) begin
               busy_nx = 1'b0;
               done_nx = 1'b1;
               cpu_nx  = 1'b1;
            end
            if (start) begin
               if (!range_ok) begin
                  err_nx   = 1'b1;
                  cpu_nx   = 1'b0;
                  state_nx = IDLE;
               end else begin
                  done_nx = 1'b0;
                  err_nx  = 1'b0;
                  cpu_nx  = 1'b0;
                  busy_nx = 1'b1;
                  len_nx  = len;
                  ptr_nx  = BASE_ADDR;
                  cnt_nx  = '0;
                  if (len != '0) begin
                     state_nx = LOAD;
                     rdy_nx   = 1'b1;
                  end else begin
                     state_nx = VEC_LO;
                  end
               end
            end
         end
         LOAD: begin
            if (s_valid && s_ready) begin
               we_nx   = 1'b1;
               addr_nx = ptr;
               din_nx  = s_data;
               ptr_nx  = ptr + ONE;
               cnt_nx  = cnt + ONE;
               if (cnt + ONE == len_q) begin
                  state_nx = VEC_LO;
                  rdy_nx   = 1'b0;
               end
            end
         end
         VEC_LO: begin
            we_nx    = 1'b1;
            addr_nx  = VEC_LOA;
            din_nx   = DATA_WIDTH'(BASE_ADDR & ADDR_WIDTH'(8'hFF));
            state_nx = VEC_HI;
         end
         VEC_HI: begin
            we_nx    = 1'b1;
            addr_nx  = VEC_HIA;
            din_nx   = DATA_WIDTH'(BASE_ADDR >> 8);
            state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers; reset aborts any load in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ptr         <= BASE_ADDR;
         cnt         <= '0;
         len_q       <= '0;
         s_ready     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= '0;
         cpu_reset_n <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         cnt         <= cnt_nx;
         len_q       <= len_nx;
         s_ready     <= rdy_nx;
         mem_we      <= we_nx;
         mem_addr    <= addr_nx;
         mem_din     <= din_nx;
         cpu_reset_n <= cpu_nx;
         busy        <= busy_nx;
         done        <= done_nx;
         err         <= err_nx;
      end
   end

endmodule
